// File: rtl/msdf_otf_converter.sv
// ----------------------------------------------------------------------------
// msdf_otf_converter
//
// On-the-fly converter for an MSD-first radix-2 signed-digit stream in
// borrow-save form (z = z_p - z_n). Each accepted digit updates a Q/QM
// register pair (QM = Q - 1 LSB at all times), so no carry ever propagates.
// After N+1 digits (one integer digit z_0 plus N fractional digits), the
// two's-complement word is registered and offered on a valid/ready handshake.
//
// Optional feature macro: MSDF_OTF_OVERRUN_EN
//   defined   -> 'overrun' port and flop present. The flag is sticky and is set
//                by any digit_valid=1 seen while a finished word waits in HOLD.
//   undefined -> no 'overrun' port; digits arriving in HOLD are dropped silently.
//
// Parameters
//   N            fractional digits per result (N >= 1)
//   W = N+2      result width (derived, LSB weight 2^-N)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   flush        synchronous abort of the current word, highest priority
//   digit_valid  z_p/z_n carry a digit this cycle
//   z_p, z_n     borrow-save digit bits: (1,0)=+1, (0,1)=-1, (0,0)/(1,1)=0
//   res_valid    res_data holds a completed word
//   res_ready    consumer accepts res_data
//   res_data     converted result, two's complement, W bits
//   busy         high while collecting digits of a word
//   overrun      sticky digit-lost flag (only with MSDF_OTF_OVERRUN_EN)
// ----------------------------------------------------------------------------
module msdf_otf_converter #(
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         digit_valid,
    input  logic         z_p,
    input  logic         z_n,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N+1:0] res_data,
    output logic         busy
`ifdef MSDF_OTF_OVERRUN_EN
    ,
    output logic         overrun
`endif
);

    localparam int W  = N + 2;
    localparam int CW = $clog2(N + 2);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_e;

    state_e          state_q;
    logic [W-1:0]    q_q;
    logic [W-1:0]    qm_q;
    logic [W-1:0]    q_d;
    logic [W-1:0]    qm_d;
    logic [CW-1:0]   cnt_q;
    logic            last_digit;

    // On-the-fly append of the incoming digit. The MSB shifted out is always
    // redundant: the result magnitude never exceeds 2^(N+1)-1 LSB.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        q_d  = {q_q[W-2:0], 1'b0};
        qm_d = {qm_q[W-2:0], 1'b1};
        if (z_p && !z_n) begin
            q_d  = {q_q[W-2:0], 1'b1};
            qm_d = {q_q[W-2:0], 1'b0};
        end else if (!z_p && z_n) begin
            q_d  = {qm_q[W-2:0], 1'b1};
            qm_d = {qm_q[W-2:0], 1'b0};
        end
    end

    // cnt is 0 in IDLE, so IDLE and COLLECT share one accept path.
    assign last_digit = (cnt_q == CW'(N));
    assign busy       = (state_q == COLLECT);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    // NOTE: the asynchronous reset clears every flop here; there is no memory
    // array, so nothing is left uninitialised.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            q_q       <= '0;
            qm_q      <= '1;
            cnt_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (flush) begin
            state_q   <= IDLE;
            q_q       <= '0;
            qm_q      <= '1;
            cnt_q     <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE, COLLECT: begin
                    if (digit_valid) begin
                        q_q   <= q_d;
                        qm_q  <= qm_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (last_digit) begin
                            state_q   <= HOLD;
                            res_data  <= q_d;
                            res_valid <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                end
                HOLD: begin
                    // Digits arriving here are not accepted; the adder has no
                    // backpressure, so they are lost.
                    if (res_ready) begin
                        state_q   <= IDLE;
                        q_q       <= '0;
                        qm_q      <= '1;
                        cnt_q     <= '0;
                        res_valid <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MSDF_OTF_OVERRUN_EN
    // Sticky until reset; a flush neither sets nor clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (!flush && state_q == HOLD && digit_valid) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule
